// File: rtl/expr_char_feeder.sv
// Front end of the expression checker: filters whitespace, buffers characters in a FIFO,
// and turns newlines into an end-of-expression pulse while tracking count and illegal chars.
module expr_char_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_eoe,
    output logic       err,
    output logic [7:0] count
);

    // Handshake: a byte transfers on any rising edge where in_valid && in_ready.
    // in_ready depends only on FIFO occupancy, never on in_valid.
    // Downstream has no back-channel beyond out_ready: each pop yields exactly one
    // cycle of out_valid (character) or out_eoe (newline), never both.

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          full;
    logic          empty;
    logic          push;
    logic          store;
    logic          pop;
    logic [7:0]    head;

    function automatic logic is_legal(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || c == 8'h2B || c == 8'h2D ||
               c == 8'h2A || c == 8'h28 || c == 8'h29;
    endfunction

    assign full     = (occ == (AW+1)'(DEPTH));
    assign empty    = (occ == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // Space and tab complete the handshake but never occupy a slot.
    assign store    = push && (in_data != 8'h20) && (in_data != 8'h09);
    assign pop      = out_ready && !empty;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({store, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out_valid <= 1'b0;
            out_eoe   <= 1'b0;
            out_data  <= 8'h00;
            err       <= 1'b0;
            count     <= 8'h00;
        end else begin
            out_valid <= 1'b0;
            out_eoe   <= 1'b0;
            if (pop) begin
                if (head == 8'h0A) begin
                    out_eoe <= 1'b1;
                    count   <= 8'h00;
                    err     <= 1'b0;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= head;
                    if (count != 8'hFF) begin
                        count <= count + 8'd1;
                    end
                    if (!is_legal(head)) begin
                        err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_expr_char_feeder.sv
// Directed bench for expr_char_feeder: cycle-accurate vector table plus hand-written
// sequences for backpressure, count saturation and asynchronous mid-stream reset.
module tb_expr_char_feeder;

  logic       clk;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_eoe;
  logic       err;
  logic [7:0] count;

  int n_checks;
  int n_fail;
  logic [7:0] exp_cnt;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       irdy;
    logic       ov;
    logic [7:0] od;
    logic       eoe;
    logic       er;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  expr_char_feeder #(.DEPTH(8), .AW(3)) dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_eoe  (out_eoe),
    .err      (err),
    .count    (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic iv, logic [7:0] id, logic ordy, logic irdy, logic ov,
                              logic [7:0] od, logic eoe, logic er, logic [7:0] cnt);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.irdy = irdy; v.ov = ov;
    v.od = od; v.eoe = eoe; v.er = er; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ov, input logic [7:0] od,
                          input logic eoe, input logic er, input logic [7:0] cnt);
    chk({tag, "_out_valid"}, 8'(out_valid), 8'(ov));
    chk({tag, "_out_data"},  out_data, od);
    chk({tag, "_out_eoe"},   8'(out_eoe), 8'(eoe));
    chk({tag, "_err"},       8'(err), 8'(er));
    chk({tag, "_count"},     count, cnt);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // "(1+2)\n": each character appears two edges after it is driven
    tbl.push_back(mk(1, 8'h28, 1, 1, 0, 8'h00, 0, 0, 8'd0));
    tbl.push_back(mk(1, 8'h31, 1, 1, 1, 8'h28, 0, 0, 8'd1));
    tbl.push_back(mk(1, 8'h2B, 1, 1, 1, 8'h31, 0, 0, 8'd2));
    tbl.push_back(mk(1, 8'h32, 1, 1, 1, 8'h2B, 0, 0, 8'd3));
    tbl.push_back(mk(1, 8'h29, 1, 1, 1, 8'h32, 0, 0, 8'd4));
    tbl.push_back(mk(1, 8'h0A, 1, 1, 1, 8'h29, 0, 0, 8'd5));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h29, 1, 0, 8'd0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h29, 0, 0, 8'd0));
    // "1 \t+ 2\n": whitespace accepted but produces no output cycle
    tbl.push_back(mk(1, 8'h31, 1, 1, 0, 8'h29, 0, 0, 8'd0));
    tbl.push_back(mk(1, 8'h20, 1, 1, 1, 8'h31, 0, 0, 8'd1));
    tbl.push_back(mk(1, 8'h09, 1, 1, 0, 8'h31, 0, 0, 8'd1));
    tbl.push_back(mk(1, 8'h2B, 1, 1, 0, 8'h31, 0, 0, 8'd1));
    tbl.push_back(mk(1, 8'h20, 1, 1, 1, 8'h2B, 0, 0, 8'd2));
    tbl.push_back(mk(1, 8'h32, 1, 1, 0, 8'h2B, 0, 0, 8'd2));
    tbl.push_back(mk(1, 8'h0A, 1, 1, 1, 8'h32, 0, 0, 8'd3));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h32, 1, 0, 8'd0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h32, 0, 0, 8'd0));
    // "1a\n": err rises with 'a', clears with the eoe pulse
    tbl.push_back(mk(1, 8'h31, 1, 1, 0, 8'h32, 0, 0, 8'd0));
    tbl.push_back(mk(1, 8'h61, 1, 1, 1, 8'h31, 0, 0, 8'd1));
    tbl.push_back(mk(1, 8'h0A, 1, 1, 1, 8'h61, 0, 1, 8'd2));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h61, 1, 0, 8'd0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h61, 0, 0, 8'd0));

    // reset state
    #12;
    chk("rst_in_ready", 8'(in_ready), 8'd1);
    chk_outs("rst", 0, 8'h00, 0, 0, 8'd0);
    @(negedge clk);
    clr = 1'b1;

    // table-driven vectors
    foreach (tbl[i]) begin
      @(negedge clk);
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 8'(in_ready), 8'(tbl[i].irdy));
      @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), tbl[i].ov, tbl[i].od, tbl[i].eoe, tbl[i].er, tbl[i].cnt);
    end

    // full / backpressure: fill 8 entries, 9th must wait for a pop
    exp_cnt = 8'd0;
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h30 + i));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'(8'h30 + i);
      #1;
      chk($sformatf("fill%0d_in_ready", i), 8'(in_ready), 8'd1);
      @(posedge clk);
    end
    #1;
    chk("full_in_ready", 8'(in_ready), 8'd0);
    chk("full_out_valid", 8'(out_valid), 8'd0);
    @(negedge clk);
    in_data = 8'h38;
    #1;
    chk("ninth_blocked", 8'(in_ready), 8'd0);
    @(posedge clk);
    #1;
    chk("ninth_no_pop", 8'(out_valid), 8'd0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        out_ready = 1'b1;
        #1;
        chk("pop_cycle_in_ready", 8'(in_ready), 8'd0);
      end
      if (k >= 2) in_valid = 1'b0;
      @(posedge clk);
      #1;
      exp_cnt = exp_cnt + 8'd1;
      chk($sformatf("drain%0d_valid", k), 8'(out_valid), 8'd1);
      chk($sformatf("drain%0d_data", k), out_data, exp_q.pop_front());
      chk($sformatf("drain%0d_count", k), count, exp_cnt);
      if (k == 0) chk("after_pop_in_ready", 8'(in_ready), 8'd1);
    end
    @(posedge clk);
    #1;
    chk("drain_done_valid", 8'(out_valid), 8'd0);

    // count saturation: 300 '1' bytes then newline
    for (int j = 0; j <= 301; j++) begin
      @(negedge clk);
      if (j < 300) begin
        in_valid = 1'b1;
        in_data  = 8'h31;
      end else if (j == 300) begin
        in_data = 8'h0A;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (j >= 1 && j <= 300) begin
        exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
        chk($sformatf("sat%0d_valid", j), 8'(out_valid), 8'd1);
        chk($sformatf("sat%0d_count", j), count, exp_cnt);
      end else if (j == 301) begin
        chk("sat_eoe", 8'(out_eoe), 8'd1);
        chk("sat_count_clear", count, 8'd0);
      end
    end
    chk("sat_reached_255", exp_cnt, 8'd255);

    // reset mid-operation: make outputs non-zero, queue 5 entries, then pulse clr
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h62;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("pre_rst", 1, 8'h62, 0, 1, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'(8'h31 + i);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    chk("midrst_in_ready", 8'(in_ready), 8'd1);
    chk_outs("midrst", 0, 8'h00, 0, 0, 8'd0);
    #1;
    clr = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_valid", i), 8'(out_valid), 8'd0);
      chk($sformatf("post_rst%0d_eoe", i), 8'(out_eoe), 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/expr_char_feeder.md
# expr_char_feeder

Upstream stage of the character-stream expression checker. It accepts ASCII characters from a producer through a valid/ready handshake and drops whitespace. It buffers the rest in a small FIFO and delivers one character per enabled cycle to the checker's `in` port. Newline characters are converted into a one-cycle end-of-expression pulse that drives the checker's clear input. The block also keeps a per-expression character count and a sticky illegal-character flag.

## Interface
- `DEPTH`, 8 — FIFO entries; power of two, ≥ 2.
- `AW`, 3 — pointer width; equals log2(DEPTH).
- `clk` input 1 — single clock; all state updates on the rising edge.
- `clr` input 1 — reset; asynchronous, active-low.
- `in_valid` input 1 — the producer offers `in_data` this cycle.
- `in_data` input 8 — ASCII character.
- `in_ready` output 1 — combinational; equals `!full`.
- `out_ready` input 1 — downstream enable; a pop is permitted this cycle.
- `out_valid` output 1 — registered; `out_data` holds a new character this cycle.
- `out_data` output 8 — registered character to the checker.
- `out_eoe` output 1 — registered one-cycle end-of-expression pulse, wired to the checker's clear.
- `err` output 1 — registered sticky flag; set when an illegal character is emitted.
- `count` output 8 — registered number of characters emitted since the last `out_eoe`; saturates at 255.

## Operation
- **Push condition:** `in_valid && in_ready`.
  - `0x20` (space) and `0x09` (tab) are accepted (handshake completes) but never stored.
  - Every other byte is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- **Pop condition:** `out_ready && !empty`. The head entry is read and `rd_ptr` increments modulo DEPTH.
  - **Head is `0x0A`:** next cycle `out_eoe`=1 and `out_valid`=0. `out_data` holds its previous value. `count` and `err` clear to 0.
  - **Any other head byte:** next cycle `out_valid`=1 and `out_data`=byte. `count` increments, saturating at 255.
    - If the byte is outside the legal set, `err` is set to 1.
    - Legal set: `'0'`–`'9'` (0x30–0x39), `'+'` 0x2B, `'-'` 0x2D, `'*'` 0x2A, `'('` 0x28, `')'` 0x29.
- **No pop:** `out_valid`=0, `out_eoe`=0, and `out_data`, `count`, `err` hold.
- **Occupancy:** an occupancy counter of width AW+1 gives `full` (occupancy = DEPTH) and `empty` (occupancy = 0).
  - Simultaneous push and pop leaves occupancy unchanged.
- **Full:** `in_ready`=0, so no push occurs even if a pop happens in the same cycle. `in_ready` rises the cycle after the pop.
- **Empty:** with `out_ready`=1, nothing is popped and the outputs deassert as in the no-pop case.
- **Reset (asynchronous, any time including mid-stream):**
  - Pointers and occupancy go to 0 and the FIFO contents are discarded.
  - `out_valid`=0, `out_eoe`=0, `out_data`=0x00, `err`=0, `count`=0.
  - `in_ready`=1 as soon as `clr` is low.

## Timing
- **Latency:** a character pushed at edge N is poppable in cycle N+1. It appears on `out_data`/`out_valid` after edge N+1, i.e. two cycles from input to output when the FIFO is empty and `out_ready` is held high.
- **Throughput:** one character per cycle in each direction.
- **Output pulses:** `out_valid` and `out_eoe` are mutually exclusive and each lasts exactly one cycle per popped entry.
- **Dropped whitespace:** costs the producer one handshake cycle and produces no output cycle.
- **Counter width:** `count` is 8 bits and sticks at 255; it does not wrap to 0.
- **`err` vs `out_eoe`:** an illegal character and the following newline pop in consecutive cycles. `err` is 1 for one cycle, then clears together with the `out_eoe` pulse.

## Test plan
- **Basic stream:** reset, `out_ready`=1, drive `"(1+2)\n"` one byte per cycle.
  - Expect `out_valid` pulses carrying 0x28, 0x31, 0x2B, 0x32, 0x29, each 2 cycles after its input.
  - Then `out_eoe`=1 with `count`=5 before it and 0 after, and `err`=0 throughout.
- **Whitespace filter:** drive `"1 \t+ 2\n"`.
  - Expect exactly 3 `out_valid` pulses (0x31, 0x2B, 0x32), then `out_eoe`.
  - `in_ready` stays 1 throughout.
- **Full / backpressure:** `out_ready`=0, push 9 non-space bytes.
  - Expect `in_ready`=0 after the 8th push, so the 9th is not accepted until a pop.
  - Set `out_ready`=1: expect the 8 bytes out in FIFO order, `in_ready`=1 one cycle after the first pop, then the 9th byte.
- **Illegal character:** drive `"1a\n"`.
  - Expect `err`=1 from the cycle 0x61 is output, held until `out_eoe`, and 0 after it.
- **Count saturation:** drive 300 `'1'` bytes then `'\n'`.
  - Expect `count` to reach 255 and hold there, then 0 after `out_eoe`.
- **Reset mid-operation:** with 5 entries queued and `out_ready`=0, pulse `clr` low between edges.
  - Expect all outputs to clear immediately and `in_ready`=1.
  - After release with `out_ready`=1, expect no stale `out_valid`.
